fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
- Sequencing controller for the radix-2 decimation-in-time FFT datapath.
- Moves the frame through three phases: load (serial-to-parallel input writes into working registers), compute (issues butterfly operand addresses and twiddle indices stage by stage), unload (parallel-to-serial readout).
- Sits between the top-level start/done interface and the s_p, butterfly, register-file and p_s blocks.
- Owns all phase, stage and butterfly counters.

Parameters:
- LOG2N, 4, log2 of FFT points (N = 2^LOG2N = 16).
- BF_LAT, 2, butterfly pipeline latency in cycles from issue to register write-back.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process one frame; sampled only in IDLE
- in_valid  in  1  s_p presents a sample
- in_ready  out  1  controller accepts a sample this cycle
- in_addr  out  LOG2N  register-file write address for the current input sample (bit-reversed)
- bf_valid  out  1  butterfly issue valid
- bf_ready  in  1  butterfly/regfile can accept an issue
- addr_a  out  LOG2N  upper operand address
- addr_b  out  LOG2N  lower operand address
- tw_idx  out  LOG2N-1  twiddle ROM index
- stage  out  LOG2N-bit (clog2)  current stage number
- scale_shift  out  1  divide-by-2 enable for the current issue
- out_valid  out  1  unload address valid to p_s
- out_ready  in  1  p_s accepts
- out_addr  out  LOG2N  register-file read address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last unload beat is accepted

Behaviour:
- Reset values (async): state=IDLE, all counters 0, in_ready=0, bf_valid=0, out_valid=0, busy=0, done=0, all address/index outputs 0.
- Outputs are registered or decoded from registered state only. No combinational path from any ready input to any valid output.

State machine:
- IDLE: start=1 -> LOAD. start in any other state is ignored.
- LOAD: in_ready=1.
  - On each in_valid handshake, load_cnt increments.
  - in_addr = bitrev(load_cnt).
  - Handshake at load_cnt=N-1 -> COMPUTE, with stage=0, k=0.
- COMPUTE: bf_valid=1. For stage s and butterfly index k (0..N/2-1):
  - span = 2^s, pos = k & (span-1).
  - addr_a = ((k >> s) << (s+1)) + pos.
  - addr_b = addr_a + span.
  - tw_idx = pos << (LOG2N-1-s), truncated to LOG2N-1 bits.
  - k advances only on bf_valid & bf_ready. Outputs hold while bf_ready=0.
  - Handshake at k=N/2-1 -> DRAIN.
- DRAIN: bf_valid=0; counts BF_LAT cycles so the last write-back lands before the next stage reads.
  - After BF_LAT cycles, if s<LOG2N-1: s+1, k=0, back to COMPUTE.
  - Otherwise -> UNLOAD.
- UNLOAD: out_valid=1, out_addr=unload_cnt (natural order).
  - unload_cnt advances on out_valid & out_ready.
  - Handshake at N-1: done=1 for that cycle -> IDLE.
- Wrap-around: all counters clear on phase exit. No counter increments past N-1 or N/2-1.
- Simultaneous events:
  - in_valid while not in LOAD: ignored (in_ready=0).
  - start in the same cycle as done: ignored; a new start is required in IDLE.
- Reset asserted mid-frame: immediate return to IDLE, frame discarded, no done pulse.
- A frame with continuous ready takes N + LOG2N*(N/2 + BF_LAT) + N cycles from start to done (LOAD through UNLOAD).

Optional Feature:
- Macro FFT_STAGE_SCALE_EN.
  - Defined: scale_shift = bf_valid during every COMPUTE issue, so the butterfly halves its outputs each stage (block-floating 1/N overall).
  - Undefined: scale_shift tied 0; port retained for interface stability.

Test Plan:
- LOG2N=4, start, 16 in_valid beats back-to-back -> in_addr sequence 0,8,4,12,2,10,...,15; in_ready drops after the 16th beat.
- Compute with bf_ready=1 -> stage0 k=0: (0,1,tw0); k=1: (2,3,tw0); stage1 k=1: (1,3,tw4); stage2 k=3: (3,7,tw6); stage3 k=7: (7,15,tw7); 2 idle DRAIN cycles between stages.
- bf_ready held low 5 cycles at stage1 k=2 -> addr_a=4, addr_b=6, tw_idx=0 held stable; issue count per stage stays exactly 8.
- Full frame with all readies=1, BF_LAT=2 -> done pulses exactly 16+4*(8+2)+16=72 cycles after the start cycle; busy=1 throughout, 0 after.
- rst_n low during stage 2 -> all valids 0 and busy 0 asynchronously; no done pulse; next start performs a complete normal frame.
- Build with FFT_STAGE_SCALE_EN -> scale_shift=1 on all 32 issues and 0 elsewhere; build without it -> scale_shift always 0.

Source files
------------

// File: rtl/fft_seq_ctrl_if.sv
// Handshake/bus bundle between the FFT sequencing controller and the
// s_p, butterfly/regfile and p_s blocks plus the start/done interface.
// master = controller side, slave = surrounding datapath/top level.
interface fft_seq_ctrl_if #(
  parameter int LOG2N = 4
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [LOG2N-1:0] in_addr;
  logic             bf_valid;
  logic             bf_ready;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [SW-1:0]    stage;
  logic             scale_shift;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2N-1:0] out_addr;
  logic             busy;
  logic             done;

  modport master (
    input  start, in_valid, bf_ready, out_ready,
    output in_ready, in_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
           scale_shift, out_valid, out_addr, busy, done
  );

  modport slave (
    output start, in_valid, bf_ready, out_ready,
    input  in_ready, in_addr, bf_valid, addr_a, addr_b, tw_idx, stage,
           scale_shift, out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a radix-2 DIT FFT: LOAD (bit-reversed writes),
// COMPUTE (butterfly address/twiddle issue per stage), DRAIN (BF_LAT idle
// cycles between stages), UNLOAD (natural-order readout).
// Optional macro FFT_STAGE_SCALE_EN: when defined, scale_shift follows
// every butterfly issue (divide-by-2 each stage); otherwise tied low.
// All outputs come from registers; no ready input reaches a valid output
// combinationally.
module fft_seq_ctrl #(
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_seq_ctrl_if.master bus
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int TW = LOG2N - 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

  state_t           state;
  logic [LOG2N-1:0] load_cnt;
  logic [TW-1:0]    k_cnt;
  logic [SW-1:0]    stg;
  logic [DW-1:0]    drn_cnt;
  logic [LOG2N-1:0] unload_cnt;

  logic             in_ready_q, bf_valid_q, out_valid_q, busy_q, done_q;
  logic [LOG2N-1:0] in_addr_q, addr_a_q, addr_b_q, out_addr_q;
  logic [TW-1:0]    tw_idx_q;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // Upper operand: group base ((k >> s) << (s+1)) plus position in group.
  function automatic logic [LOG2N-1:0] op_a(input logic [TW-1:0] k,
                                            input logic [SW-1:0] s);
    logic [LOG2N-1:0] kx, pos, base;
    kx   = {1'b0, k};
    pos  = kx & ((LOG2N'(1) << s) - LOG2N'(1));
    base = (kx >> s) << (int'(s) + 1);
    return base + pos;
  endfunction

  function automatic logic [LOG2N-1:0] op_b(input logic [TW-1:0] k,
                                            input logic [SW-1:0] s);
    return op_a(k, s) + (LOG2N'(1) << s);
  endfunction

  // At the last stage the span mask wraps to all ones, which is exactly
  // the full-width k needed there.
  function automatic logic [TW-1:0] tw_of(input logic [TW-1:0] k,
                                          input logic [SW-1:0] s);
    logic [TW-1:0] pos;
    pos = k & ((TW'(1) << s) - TW'(1));
    return pos << (TW - int'(s));
  endfunction

  // Phase FSM, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      load_cnt    <= '0;
      k_cnt       <= '0;
      stg         <= '0;
      drn_cnt     <= '0;
      unload_cnt  <= '0;
      in_ready_q  <= 1'b0;
      bf_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_addr_q   <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_idx_q    <= '0;
      out_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // done is high in the first IDLE cycle; a start there is dropped.
          if (bus.start && !done_q) begin
            state      <= LOAD;
            load_cnt   <= '0;
            in_addr_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            if (&load_cnt) begin
              state      <= COMPUTE;
              load_cnt   <= '0;
              in_ready_q <= 1'b0;
              in_addr_q  <= '0;
              stg        <= '0;
              k_cnt      <= '0;
              bf_valid_q <= 1'b1;
              addr_a_q   <= op_a('0, '0);
              addr_b_q   <= op_b('0, '0);
              tw_idx_q   <= tw_of('0, '0);
            end else begin
              load_cnt  <= load_cnt + 1'b1;
              in_addr_q <= bitrev(load_cnt + 1'b1);
            end
          end
        end
        COMPUTE: begin
          if (bus.bf_ready) begin
            if (&k_cnt) begin
              state      <= DRAIN;
              k_cnt      <= '0;
              drn_cnt    <= '0;
              bf_valid_q <= 1'b0;
              addr_a_q   <= '0;
              addr_b_q   <= '0;
              tw_idx_q   <= '0;
            end else begin
              k_cnt    <= k_cnt + 1'b1;
              addr_a_q <= op_a(k_cnt + 1'b1, stg);
              addr_b_q <= op_b(k_cnt + 1'b1, stg);
              tw_idx_q <= tw_of(k_cnt + 1'b1, stg);
            end
          end
        end
        DRAIN: begin
          if (drn_cnt == DW'(BF_LAT - 1)) begin
            drn_cnt <= '0;
            if (stg == SW'(LOG2N - 1)) begin
              state       <= UNLOAD;
              stg         <= '0;
              unload_cnt  <= '0;
              out_addr_q  <= '0;
              out_valid_q <= 1'b1;
            end else begin
              state      <= COMPUTE;
              stg        <= stg + 1'b1;
              bf_valid_q <= 1'b1;
              addr_a_q   <= op_a('0, stg + 1'b1);
              addr_b_q   <= op_b('0, stg + 1'b1);
              tw_idx_q   <= tw_of('0, stg + 1'b1);
            end
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            if (&unload_cnt) begin
              state       <= IDLE;
              unload_cnt  <= '0;
              out_addr_q  <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              unload_cnt <= unload_cnt + 1'b1;
              out_addr_q <= unload_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.bf_valid  = bf_valid_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_b    = addr_b_q;
  assign bus.tw_idx    = tw_idx_q;
  assign bus.stage     = stg;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef FFT_STAGE_SCALE_EN
  assign bus.scale_shift = bf_valid_q;
`else
  assign bus.scale_shift = 1'b0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl (LOG2N=4, BF_LAT=2): stimulus pushes
// expected beats into queues, a negedge monitor pops and compares on every
// handshake. Directed frames: back-to-back, stalled/gapped, reset mid-frame.
module tb_fft_seq_ctrl;
  localparam int LOG2N = 4;
  localparam int N     = 16;

`ifdef FFT_STAGE_SCALE_EN
  localparam int SCALE_ON = 1;
`else
  localparam int SCALE_ON = 0;
`endif

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
  } bf_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fft_seq_ctrl_if #(.LOG2N(LOG2N)) bus ();

  fft_seq_ctrl #(.LOG2N(LOG2N), .BF_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_in[$];
  int exp_out[$];
  bf_t exp_bf[$];
  bf_t act_log[$];
  bit log_en = 0;
  int issues[4];
  int mode = 0;

  // Bit-reversed load order for 16 points, written out by hand.
  int brev[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected beats for one frame: butterflies enumerated as groups of
  // 2*span with j walking the span; twiddle step is N/(2*span).
  task automatic push_frame();
    bf_t e;
    for (int i = 0; i < N; i++) exp_in.push_back(brev[i]);
    for (int s = 0; s < LOG2N; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++)
        for (int j = 0; j < span; j++) begin
          e.a  = g * 2 * span + j;
          e.b  = e.a + span;
          e.tw = j * (N / (2 * span));
          e.st = s;
          exp_bf.push_back(e);
        end
    end
    for (int i = 0; i < N; i++) exp_out.push_back(i);
  endtask

  task automatic clear_q();
    exp_in.delete();
    exp_bf.delete();
    exp_out.delete();
  endtask

  // Input pattern driver: mode 0 always ready/valid, mode 1 with gaps.
  initial begin
    int gc = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      gc++;
      if (mode == 1) begin
        bus.in_valid  = (gc % 3) != 0;
        bus.out_ready = (gc % 4) != 1;
      end else begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake.
  initial begin
    bf_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_valid && bus.in_ready) begin
          chk("in_beat_expected", int'(exp_in.size() > 0), 1);
          if (exp_in.size() > 0) chk("in_addr", int'(bus.in_addr), exp_in.pop_front());
        end
        if (bus.bf_valid && bus.bf_ready) begin
          a.a = int'(bus.addr_a); a.b = int'(bus.addr_b);
          a.tw = int'(bus.tw_idx); a.st = int'(bus.stage);
          if (log_en) act_log.push_back(a);
          issues[a.st]++;
          chk("scale_on_issue", int'(bus.scale_shift), SCALE_ON);
          chk("bf_issue_expected", int'(exp_bf.size() > 0), 1);
          if (exp_bf.size() > 0) begin
            e = exp_bf.pop_front();
            chk("addr_a", a.a, e.a);
            chk("addr_b", a.b, e.b);
            chk("tw_idx", a.tw, e.tw);
            chk("stage", a.st, e.st);
          end
        end
        if (!bus.bf_valid) chk("scale_idle", int'(bus.scale_shift), 0);
        if (bus.out_valid && bus.out_ready) begin
          chk("out_beat_expected", int'(exp_out.size() > 0), 1);
          if (exp_out.size() > 0) chk("out_addr", int'(bus.out_addr), exp_out.pop_front());
        end
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done is seen.
  task automatic wait_done(output int cyc);
    int busy_bad = 0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done) break;
      @(posedge clk); #1;
      cyc++;
      if (!bus.done && !bus.busy) busy_bad++;
    end
    chk("done_seen", int'(bus.done), 1);
    chk("busy_during_frame", busy_bad, 0);
    chk("busy_at_done", int'(bus.busy), 0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_in_q_left"},  exp_in.size(),  0);
    chk({tag, "_bf_q_left"},  exp_bf.size(),  0);
    chk({tag, "_out_q_left"}, exp_out.size(), 0);
  endtask

  initial begin
    int cyc, found, dcnt;
    bus.start    = 1'b0;
    bus.bf_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready",  int'(bus.in_ready), 0);
    chk("rst_bf_valid",  int'(bus.bf_valid), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_addrs",     int'(bus.in_addr) + int'(bus.addr_a) + int'(bus.addr_b) +
                         int'(bus.tw_idx) + int'(bus.out_addr) + int'(bus.stage), 0);
    chk("rst_scale",     int'(bus.scale_shift), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start_busy", int'(bus.busy), 0);

    // Frame 1: all readies high, latency and hand-computed issue spots
    push_frame();
    log_en = 1;
    start_frame();
    wait_done(cyc);
    log_en = 0;
    chk("done_latency", cyc, 72);
    bus.start = 1'b1;             // start while done is high: dropped
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("done_width", int'(bus.done), 0);
    chk("start_on_done_ignored", int'(bus.busy), 0);
    chk_drained("f1");
    chk("issue_total", act_log.size(), 32);
    if (act_log.size() == 32) begin
      chk("s0k0_a", act_log[0].a, 0);   chk("s0k0_b", act_log[0].b, 1);   chk("s0k0_tw", act_log[0].tw, 0);
      chk("s0k1_a", act_log[1].a, 2);   chk("s0k1_b", act_log[1].b, 3);   chk("s0k1_tw", act_log[1].tw, 0);
      chk("s1k1_a", act_log[9].a, 1);   chk("s1k1_b", act_log[9].b, 3);   chk("s1k1_tw", act_log[9].tw, 4);
      chk("s2k3_a", act_log[19].a, 3);  chk("s2k3_b", act_log[19].b, 7);  chk("s2k3_tw", act_log[19].tw, 6);
      chk("s3k7_a", act_log[31].a, 7);  chk("s3k7_b", act_log[31].b, 15); chk("s3k7_tw", act_log[31].tw, 7);
    end

    // Frame 2: gapped input/output, bf_ready stall at stage 1 k=2
    mode = 1;
    for (int s = 0; s < 4; s++) issues[s] = 0;
    push_frame();
    start_frame();
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.bf_valid && bus.stage == 2'd1 && bus.addr_a == 4'd4) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stall_point_found", found, 1);
    bus.bf_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(bus.bf_valid), 1);
      chk("stall_addr_a", int'(bus.addr_a), 4);
      chk("stall_addr_b", int'(bus.addr_b), 6);
      chk("stall_tw", int'(bus.tw_idx), 0);
    end
    bus.bf_ready = 1'b1;
    wait_done(cyc);
    for (int s = 0; s < 4; s++) chk($sformatf("issues_stage%0d", s), issues[s], 8);
    chk_drained("f2");
    mode = 0;

    // Frame 3: reset during stage 2
    push_frame();
    start_frame();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.bf_valid && bus.stage == 2'd2) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stage2_found", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bf_valid", int'(bus.bf_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_stage", int'(bus.stage), 0);
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);

    // Frame 4: normal frame after the aborted one
    push_frame();
    start_frame();
    wait_done(cyc);
    chk("done_latency_f4", cyc, 72);
    @(posedge clk); #1;
    chk_drained("f4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
